// File: rtl/dac_spi_pkg.sv
// Shared constants for the APD bias DAC SPI writer: FSM encodings,
// frame layout and the frame builder.
package dac_spi_pkg;

    localparam int DAC_W      = 10;
    localparam int FRAME_BITS = 16;
    localparam int PAD_HI_W   = 2;
    localparam int PAD_LO_W   = 2;

    localparam logic [1:0] PWR_MODE = 2'b00;

    localparam logic [7:0] ST_IDLE  = 8'b0000_0001;
    localparam logic [7:0] ST_LOAD  = 8'b0000_0010;
    localparam logic [7:0] ST_SHIFT = 8'b0000_0100;
    localparam logic [7:0] ST_GAP   = 8'b0000_1000;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [DAC_W-1:0] code
    );
        return {{PAD_HI_W{1'b0}}, PWR_MODE, code, {PAD_LO_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dac_spi_writer_ramp.sv
// Slew limiter: moves cur toward target by at most step per frame.
module dac_ramp_calc
    import dac_spi_pkg::*;
(
    input  logic [DAC_W-1:0] cur_i,
    input  logic [DAC_W-1:0] target_i,
    input  logic [DAC_W-1:0] step_i,
    output logic [DAC_W-1:0] next_o
);

    always_comb begin
        next_o = target_i;
        if (target_i > cur_i) begin
            if (target_i - cur_i > step_i) next_o = cur_i + step_i;
        end else if (cur_i - target_i > step_i) begin
            next_o = cur_i - step_i;
        end
    end

endmodule

// File: rtl/dac_spi_writer.sv
// SPI writer for the 10-bit APD bias DAC (16-bit frames, MSB first).
// Define DAC_WRITER_RAMP_EN to slew-limit each frame by RAMP_STEP.
module dac_spi_writer
    import dac_spi_pkg::*;
#(
    parameter int               CLK_DIV   = 4,
    parameter int               SYNC_GAP  = 4,
    parameter logic [DAC_W-1:0] RAMP_STEP = 10'd8
) (
    input  logic             i_clk_50m,
    input  logic             i_rst_n,
    input  logic             i_dac_start,
    input  logic [DAC_W-1:0] i_dac_value,
    output logic             o_dac_sclk,
    output logic             o_dac_sync_n,
    output logic             o_dac_sdin,
    output logic             o_dac_busy,
    output logic             o_dac_done,
    output logic [DAC_W-1:0] o_dac_cur_value
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(SYNC_GAP - 1);
    localparam logic [3:0]  BIT_LAST = 4'(FRAME_BITS - 1);

    logic [7:0]            state_q, state_d;
    logic [DAC_W-1:0]      target_q, target_d;
    logic [DAC_W-1:0]      next_q, next_d;
    logic [DAC_W-1:0]      cur_q, cur_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  sclk_q, sclk_d;
    logic                  sync_n_q, sync_n_d;
    logic                  sdin_q, sdin_d;
    logic [DAC_W-1:0]      ramp_next;
    logic [FRAME_BITS-1:0] frame;

`ifdef DAC_WRITER_RAMP_EN
    dac_ramp_calc u_ramp (
        .cur_i    (cur_q),
        .target_i (target_q),
        .step_i   (RAMP_STEP),
        .next_o   (ramp_next)
    );
`else
    logic ramp_step_unused;
    assign ramp_step_unused = ^RAMP_STEP;
    assign ramp_next        = target_q;
`endif

    assign frame = build_frame(ramp_next);

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        next_d    = next_q;
        cur_d     = cur_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        sync_n_d  = sync_n_q;
        sdin_d    = sdin_q;

        // Later requests overwrite the target; the frame in flight is untouched.
        if (i_dac_start) target_d = i_dac_value;
        if (i_dac_start && state_q != ST_IDLE) pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy_d = i_dac_start;
                if (i_dac_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                next_d   = ramp_next;
                shreg_d  = frame;
                sdin_d   = frame[FRAME_BITS-1];
                sync_n_d = 1'b0;
                sclk_d   = 1'b1;
                cnt_d    = '0;
                bit_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else if (bit_q == BIT_LAST) begin
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        sdin_d   = 1'b0;
                        cur_d    = next_q;
                        state_d  = ST_GAP;
                    end else begin
                        sclk_d  = 1'b1;
                        bit_d   = bit_q + 4'd1;
                        shreg_d = shreg_q << 1;
                        sdin_d  = shreg_q[FRAME_BITS-2];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (pending_q || i_dac_start || cur_q != target_d) begin
                        pending_d = 1'b0;
                        state_d   = ST_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            next_q    <= '0;
            cur_q     <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b1;
            sync_n_q  <= 1'b1;
            sdin_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            next_q    <= next_d;
            cur_q     <= cur_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            sync_n_q  <= sync_n_d;
            sdin_q    <= sdin_d;
        end
    end

    assign o_dac_sclk      = sclk_q;
    assign o_dac_sync_n    = sync_n_q;
    assign o_dac_sdin      = sdin_q;
    assign o_dac_busy      = busy_q;
    assign o_dac_done      = done_q;
    assign o_dac_cur_value = cur_q;

endmodule

// File: doc/dac_spi_writer.md
# dac_spi_writer

Serialises the 10-bit APD high-voltage code from the temperature-compensation stage into 16-bit SPI frames for the external 10-bit DAC. It accepts the one-cycle start pulse and value that the compensation block produces, then drives SCLK, SYNC_n and SDIN. It reports busy/done and the code last written to the DAC. With the ramp option compiled in, it limits the per-frame code change, giving the APD bias a soft start and slew limit.

## Interface
- CLK_DIV, 4: SCLK half-period in i_clk_50m cycles (≥1); SCLK = 50 MHz / (2·CLK_DIV).
- SYNC_GAP, 4: minimum cycles SYNC_n held high between frames (≥1).
- RAMP_STEP, 10'd8: maximum code change per frame (ramp builds only; ≥1).
- i_clk_50m  in  1  system clock, 50 MHz.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_dac_start  in  1  one-cycle request; i_dac_value sampled in the same cycle.
- i_dac_value  in  10  target DAC code.
- o_dac_sclk  out  1  SPI clock; idles high.
- o_dac_sync_n  out  1  frame select, active low.
- o_dac_sdin  out  1  serial data, MSB first.
- o_dac_busy  out  1  high from the cycle after an accepted start until done.
- o_dac_done  out  1  one-cycle pulse when the DAC holds the target and no request is pending.
- o_dac_cur_value  out  10  code last fully shifted into the DAC.

## Operation
- States (one-hot, 8-bit): IDLE, LOAD, SHIFT, GAP.
- IDLE: on i_dac_start, latch r_target ← i_dac_value, go to LOAD.
- LOAD, 1 cycle: compute r_next.
  - Without ramp: r_next = r_target.
  - With ramp: r_next = r_target if |r_target − cur| ≤ RAMP_STEP, else cur ± RAMP_STEP.
  - Build the frame {4'b0000, r_next, 2'b00}. Leading bits 00 = normal power mode.
- SHIFT: 16 bits, MSB first.
  - Each bit lasts 2·CLK_DIV cycles: CLK_DIV cycles SCLK high, then CLK_DIV cycles SCLK low.
  - SDIN changes only at bit start, while SCLK is high. The DAC samples on the falling edge.
- SHIFT end: SYNC_n goes high and SCLK stays high; cur ← r_next; go to GAP.
- GAP: hold for SYNC_GAP cycles. Then:
  - if a request is pending, or cur ≠ r_target: go to LOAD;
  - otherwise: pulse o_dac_done and go to IDLE.
- i_dac_start while busy: overwrite r_target, set pending. The frame in flight is never aborted or modified. Multiple starts collapse; the last value wins.
- i_dac_start in the same cycle that done pulses: accepted; the next LOAD follows IDLE on the next cycle.
- Reset values: sclk 1, sync_n 1, sdin 0, busy 0, done 0, cur_value 0, state IDLE, pending 0.
- Reset mid-frame: every output returns to its reset value immediately and asynchronously. The partial frame and any pending request are discarded.

## Timing
- Start sampled at edge T → LOAD at T+1 → sync_n low, bit 15 on sdin, sclk high at T+2.
- sync_n low for exactly 32·CLK_DIV cycles (128 at default).
- cur_value updates on the same edge that sync_n rises.
- Without ramp, single request: done at T+2+32·CLK_DIV+SYNC_GAP (134 at default).
- busy is high from T+1 through the done cycle inclusive.
- With ramp: each further frame adds 1 + 32·CLK_DIV + SYNC_GAP cycles.

## Configuration
- DAC_WRITER_RAMP_EN
  - Defined: LOAD applies the RAMP_STEP limit, and the block repeats frames until cur equals the target.
  - Undefined: exactly one frame per request (plus at most one for a pending request); RAMP_STEP is ignored.

## Structure
- Shared package dac_spi_pkg: one-hot state constants, FRAME_BITS = 16, power-mode bits 2'b00, pad widths.
- Sub-module dac_ramp_calc (combinational: cur, target, step → next), instantiated only under DAC_WRITER_RAMP_EN.
- All counters, shift register and SPI pins in the top module.

## Test plan
- No ramp, start with 10'h2A5:
  - frame 16'h0A94 captured on SCLK falling edges;
  - sync_n low 128 cycles; cur_value = 10'h2A5;
  - done one cycle at T+134.
- Ramp, cur 0, target 20, step 8:
  - three frames with codes 8, 16, 20;
  - busy held throughout; a single done after the third frame.
- Ramp down, cur 20, target 5: frames 12, 5; then done.
- Start 10'h100 mid-frame, then 10'h200 two cycles later:
  - the current frame completes unchanged;
  - exactly one further frame with 10'h200; one done.
- Reset asserted 40 cycles into a frame:
  - sclk = 1, sync_n = 1, sdin = 0, busy = 0, cur_value = 0 immediately;
  - no frame after release until a new start.
- CLK_DIV = 1, SYNC_GAP = 1: sclk toggles every cycle, sync_n low 32 cycles, done at T+35.
